// File: rtl/contador_pkg.sv
// Shared definitions for the 4-bit mode counter and its job sequencer.
package contador_pkg;

  localparam int unsigned CNT_W = 4;

  // Counter mode codes, also used as job modes.
  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// Two-way round-robin arbiter: pointer picks the winner when both request,
// and moves to the other requester when a job finishes.
module arbitro_rr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Pointer moves to the requester that did not just finish.
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = ~upd_id_i;
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  // One-hot grant.
  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/controlador_contador.sv
// Two-requester job sequencer for the external 4-bit mode counter.
// Each job loads a start value, runs N enabled steps and reports final Q.
module controlador_contador
  import contador_pkg::*;
#(
  parameter int unsigned PASOS_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               VALID0,
  input  logic               VALID1,
  input  logic [1:0]         MODO0,
  input  logic [1:0]         MODO1,
  input  logic [CNT_W-1:0]   D0,
  input  logic [CNT_W-1:0]   D1,
  input  logic [PASOS_W-1:0] PASOS0,
  input  logic [PASOS_W-1:0] PASOS1,
  output logic               READY0,
  output logic               READY1,
  output logic               ENB_C,
  output logic [1:0]         MODO_C,
  output logic [CNT_W-1:0]   D_C,
  input  logic [CNT_W-1:0]   Q_C,
  output logic               DONE,
  output logic [CNT_W-1:0]   RESULT,
  output logic               RESULT_ID,
  output logic               BUSY
);

  estado_t              state_q, state_d;
  logic                 id_q, id_d;
  logic [1:0]           modo_q, modo_d;
  logic [CNT_W-1:0]     d_q, d_d;
  logic [PASOS_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]     result_q, result_d;
  logic                 result_id_q, result_id_d;

  logic [1:0] gnt;
  logic       accept;

  arbitro_rr u_arbitro (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .req_i    ({VALID1, VALID0}),
    .upd_i    (state_q == ST_DONE),
    .upd_id_i (id_q),
    .gnt_o    (gnt)
  );

  assign accept = (state_q == ST_IDLE) && !RESET && (VALID0 || VALID1);
  assign READY0 = accept && gnt[0];
  assign READY1 = accept && gnt[1];

  // State and job registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      id_q        <= 1'b0;
      modo_q      <= '0;
      d_q         <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      result_id_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      modo_q      <= modo_d;
      d_q         <= d_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  // Next-state, job capture and step countdown.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    modo_d      = modo_q;
    d_d         = d_q;
    rem_d       = rem_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          id_d    = gnt[1];
          modo_d  = gnt[1] ? MODO1  : MODO0;
          d_d     = gnt[1] ? D1     : D0;
          rem_d   = gnt[1] ? PASOS1 : PASOS0;
        end
      end
      ST_LOAD: begin
        if ((rem_q != '0) && (modo_q != MODO_LOAD)) state_d = ST_RUN;
        else                                        state_d = ST_DONE;
      end
      ST_RUN: begin
        rem_d = rem_q - PASOS_W'(1);
        if (rem_q == PASOS_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_d    = Q_C;
        result_id_d = id_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter drive and status outputs decoded from state.
  // The counter only settles on its final value after the last RUN edge, so
  // during DONE the result is forwarded straight from Q_C; the registered
  // copy holds it afterwards.
  always_comb begin
    ENB_C     = 1'b0;
    MODO_C    = MODO_UP;
    D_C       = '0;
    DONE      = 1'b0;
    BUSY      = (state_q != ST_IDLE);
    RESULT    = result_q;
    RESULT_ID = result_id_q;
    case (state_q)
      ST_LOAD: begin
        ENB_C  = 1'b1;
        MODO_C = MODO_LOAD;
        D_C    = d_q;
      end
      ST_RUN: begin
        ENB_C  = 1'b1;
        MODO_C = modo_q;
        D_C    = d_q;
      end
      ST_DONE: begin
        DONE      = 1'b1;
        RESULT    = Q_C;
        RESULT_ID = id_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controlador_contador.sv
// Directed bench for controlador_contador with a behavioural 4-bit counter.
module tb_controlador_contador;

  logic       CLK, RESET, VALID0, VALID1;
  logic [1:0] MODO0, MODO1;
  logic [3:0] D0, D1;
  logic [7:0] PASOS0, PASOS1;
  logic       READY0, READY1, ENB_C;
  logic [1:0] MODO_C;
  logic [3:0] D_C, Q_C;
  logic       DONE;
  logic [3:0] RESULT;
  logic       RESULT_ID, BUSY;

  int checks = 0;
  int errors = 0;

  controlador_contador #(.PASOS_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .VALID0(VALID0), .VALID1(VALID1),
    .MODO0(MODO0), .MODO1(MODO1), .D0(D0), .D1(D1),
    .PASOS0(PASOS0), .PASOS1(PASOS1), .READY0(READY0), .READY1(READY1),
    .ENB_C(ENB_C), .MODO_C(MODO_C), .D_C(D_C), .Q_C(Q_C),
    .DONE(DONE), .RESULT(RESULT), .RESULT_ID(RESULT_ID), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External counter model.
  initial Q_C = 4'h6;
  always @(posedge CLK) begin
    if (ENB_C) begin
      case (MODO_C)
        2'b00:   Q_C <= Q_C + 4'd1;
        2'b01:   Q_C <= Q_C - 4'd1;
        2'b10:   Q_C <= Q_C - 4'd3;
        default: Q_C <= D_C;
      endcase
    end
  end

  // Runs one job from one requester; returns observations only.
  task automatic do_job(input int req, input logic [1:0] modo, input logic [3:0] d,
                        input logic [7:0] pasos, output int lat, output logic [3:0] res,
                        output logic rid, output logic busy_all, output logic [6:0] ld,
                        output logic [1:0] run_modo, output logic done_enb);
    int w;
    lat = -1; res = 'x; rid = 'x; busy_all = 1'b1; ld = 'x; run_modo = 'x; done_enb = 'x;
    if (req == 0) begin VALID0 = 1'b1; MODO0 = modo; D0 = d; PASOS0 = pasos; end
    else          begin VALID1 = 1'b1; MODO1 = modo; D1 = d; PASOS1 = pasos; end
    w = 0;
    #1;
    while (!((req == 0) ? READY0 : READY1) && w < 50) begin
      @(negedge CLK); #1; w++;
    end
    if (w < 50) begin
      @(posedge CLK);
      @(negedge CLK);
      ld = {ENB_C, MODO_C, D_C};
      // Payload changes after the handshake must be ignored.
      if (req == 0) begin VALID0 = 1'b0; MODO0 = ~modo; D0 = ~d; PASOS0 = pasos + 8'd7; end
      else          begin VALID1 = 1'b0; MODO1 = ~modo; D1 = ~d; PASOS1 = pasos + 8'd7; end
      for (int k = 1; k <= 300; k++) begin
        if (k == 2) run_modo = MODO_C;
        if (!BUSY) busy_all = 1'b0;
        if (DONE) begin
          lat = k; res = RESULT; rid = RESULT_ID; done_enb = ENB_C;
          break;
        end
        @(negedge CLK);
      end
    end else begin
      VALID0 = 1'b0; VALID1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; VALID0 = 1'b1; D0 = 4'h5; MODO0 = 2'b00; PASOS0 = 8'd2;
    @(negedge CLK); @(negedge CLK);
    checks++;
    if ({READY0, READY1, BUSY, DONE, ENB_C, MODO_C, D_C, RESULT, RESULT_ID} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000",
               {READY0, READY1, BUSY, DONE, ENB_C, MODO_C, D_C, RESULT, RESULT_ID});
    end
    VALID0 = 1'b0; RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_up_req0();
    int lat; logic [3:0] res; logic rid, busy_all, done_enb; logic [6:0] ld; logic [1:0] rm;
    do_job(0, 2'b00, 4'hE, 8'd3, lat, res, rid, busy_all, ld, rm, done_enb);
    checks++; if (lat !== 5) begin errors++; $display("FAIL up_latency: got %0d want 5", lat); end
    checks++; if (res !== 4'h1) begin errors++; $display("FAIL up_result: got %h want 1", res); end
    checks++; if (rid !== 1'b0) begin errors++; $display("FAIL up_id: got %b want 0", rid); end
    checks++; if (ld !== {1'b1, 2'b11, 4'hE}) begin errors++; $display("FAIL up_load_drive: got %h want %h", ld, {1'b1, 2'b11, 4'hE}); end
    checks++; if (rm !== 2'b00) begin errors++; $display("FAIL up_run_modo: got %b want 00", rm); end
    checks++; if (done_enb !== 1'b0) begin errors++; $display("FAIL up_done_enb: got %b want 0", done_enb); end
    checks++; if (busy_all !== 1'b1) begin errors++; $display("FAIL up_busy: got %b want 1", busy_all); end
    @(negedge CLK);
  endtask

  task automatic test_down3_req1();
    int lat; logic [3:0] res; logic rid, busy_all, done_enb; logic [6:0] ld; logic [1:0] rm;
    do_job(1, 2'b10, 4'h2, 8'd2, lat, res, rid, busy_all, ld, rm, done_enb);
    checks++; if (lat !== 4) begin errors++; $display("FAIL dn3_latency: got %0d want 4", lat); end
    checks++; if (res !== 4'hC) begin errors++; $display("FAIL dn3_result: got %h want c", res); end
    checks++; if (rid !== 1'b1) begin errors++; $display("FAIL dn3_id: got %b want 1", rid); end
    checks++; if (rm !== 2'b10) begin errors++; $display("FAIL dn3_run_modo: got %b want 10", rm); end
    @(negedge CLK);
  endtask

  task automatic test_load_only();
    int lat; logic [3:0] res; logic rid, busy_all, done_enb; logic [6:0] ld; logic [1:0] rm;
    do_job(0, 2'b11, 4'h9, 8'd5, lat, res, rid, busy_all, ld, rm, done_enb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ldonly_latency: got %0d want 2", lat); end
    checks++; if (res !== 4'h9) begin errors++; $display("FAIL ldonly_result: got %h want 9", res); end
    @(negedge CLK);
    do_job(0, 2'b01, 4'h7, 8'd0, lat, res, rid, busy_all, ld, rm, done_enb);
    checks++; if (lat !== 2) begin errors++; $display("FAIL zero_latency: got %0d want 2", lat); end
    checks++; if (res !== 4'h7) begin errors++; $display("FAIL zero_result: got %h want 7", res); end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int lat;
    RESET = 1'b1; @(negedge CLK); RESET = 1'b0;
    VALID0 = 1'b1; MODO0 = 2'b00; D0 = 4'h1; PASOS0 = 8'd1;
    VALID1 = 1'b1; MODO1 = 2'b01; D1 = 4'h8; PASOS1 = 8'd2;
    #1;
    checks++; if ({READY1, READY0} !== 2'b01) begin errors++; $display("FAIL b2b_grant0: got %b want 01", {READY1, READY0}); end
    @(posedge CLK); @(negedge CLK);
    VALID0 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (DONE) begin lat = k; break; end
      @(negedge CLK);
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_lat0: got %0d want 3", lat); end
    checks++; if ({RESULT_ID, RESULT} !== {1'b0, 4'h2}) begin errors++; $display("FAIL b2b_res0: got %h want 02", {RESULT_ID, RESULT}); end
    @(negedge CLK);
    checks++; if ({BUSY, READY1, READY0} !== 3'b010) begin errors++; $display("FAIL b2b_idle_grant1: got %b want 010", {BUSY, READY1, READY0}); end
    @(posedge CLK); @(negedge CLK);
    VALID1 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (DONE) begin lat = k; break; end
      @(negedge CLK);
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_lat1: got %0d want 4", lat); end
    checks++; if ({RESULT_ID, RESULT} !== {1'b1, 4'h6}) begin errors++; $display("FAIL b2b_res1: got %h want 16", {RESULT_ID, RESULT}); end
    @(negedge CLK);
    VALID0 = 1'b1; VALID1 = 1'b1;
    #1;
    checks++; if ({READY1, READY0} !== 2'b01) begin errors++; $display("FAIL b2b_ptr_back0: got %b want 01", {READY1, READY0}); end
    VALID0 = 1'b0; VALID1 = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_run();
    int lat, dones; logic [3:0] res; logic rid, busy_all, done_enb; logic [6:0] ld; logic [1:0] rm;
    VALID0 = 1'b1; MODO0 = 2'b00; D0 = 4'h3; PASOS0 = 8'd8;
    #1;
    checks++; if (READY0 !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", READY0); end
    @(posedge CLK); @(negedge CLK);   // LOAD
    VALID0 = 1'b0;
    @(negedge CLK); @(negedge CLK); @(negedge CLK);  // third RUN cycle
    checks++; if ({BUSY, ENB_C, MODO_C} !== 4'b1100) begin errors++; $display("FAIL mid_running: got %b want 1100", {BUSY, ENB_C, MODO_C}); end
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if ({READY0, READY1, BUSY, DONE, ENB_C, MODO_C, D_C, RESULT, RESULT_ID} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h want 0000",
               {READY0, READY1, BUSY, DONE, ENB_C, MODO_C, D_C, RESULT, RESULT_ID});
    end
    RESET = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (DONE || BUSY) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    do_job(1, 2'b01, 4'h5, 8'd2, lat, res, rid, busy_all, ld, rm, done_enb);
    checks++; if (lat !== 4) begin errors++; $display("FAIL after_reset_latency: got %0d want 4", lat); end
    checks++; if ({rid, res} !== {1'b1, 4'h3}) begin errors++; $display("FAIL after_reset_result: got %h want 13", {rid, res}); end
    @(negedge CLK);
  endtask

  task automatic test_max_pasos();
    int lat; logic [3:0] res; logic rid, busy_all, done_enb; logic [6:0] ld; logic [1:0] rm;
    do_job(0, 2'b01, 4'h0, 8'd255, lat, res, rid, busy_all, ld, rm, done_enb);
    checks++; if (lat !== 257) begin errors++; $display("FAIL max_latency: got %0d want 257", lat); end
    checks++; if (res !== 4'h1) begin errors++; $display("FAIL max_result: got %h want 1", res); end
    checks++; if (busy_all !== 1'b1) begin errors++; $display("FAIL max_busy: got %b want 1", busy_all); end
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; VALID0 = 1'b0; VALID1 = 1'b0;
    MODO0 = '0; MODO1 = '0; D0 = '0; D1 = '0; PASOS0 = '0; PASOS1 = '0;
    test_reset();
    test_up_req0();
    test_down3_req1();
    test_load_only();
    test_back_to_back();
    test_reset_mid_run();
    test_max_pasos();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/controlador_contador.md
# controlador_contador

Two-requester sequencer for the shared 4-bit mode counter (`contador`: up +1, down −1, down −3, parallel load; 4-bit wrap; registered on CLK when ENB). It accepts counting jobs from two requesters over valid/ready, arbitrates them round-robin, and drives the counter's ENB/MODO/D. For each job it loads a start value, runs the requested number of enabled steps, and returns the final Q tagged with the requester ID.

## Interface
- PASOS_W, 8, width of the step-count field per job.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- VALID0 / VALID1  in  1  requester n presents a job.
- MODO0 / MODO1  in  2  job mode: 00 up, 01 down, 10 down-by-3, 11 load-only.
- D0 / D1  in  4  job start value.
- PASOS0 / PASOS1  in  PASOS_W  number of enabled counting edges after the load.
- READY0 / READY1  out  1  combinational accept; a job transfers on VALIDn && READYn.
- ENB_C  out  1  counter enable.
- MODO_C  out  2  counter mode select.
- D_C  out  4  counter parallel-load data.
- Q_C  in  4  counter output.
- DONE  out  1  one-cycle pulse: RESULT/RESULT_ID valid.
- RESULT  out  4  final counter value of the finished job.
- RESULT_ID  out  1  requester that owned the finished job.
- BUSY  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - All counter outputs are 0.
  - If any VALIDn is high, assert READY for the arbiter's grant only.
  - Capture that requester's MODO/D/PASOS and ID, then go to LOAD.
- Arbitration: round-robin pointer, reset to 0.
  - Both valid: the pointer wins.
  - One valid: that one wins.
  - On DONE the pointer moves to the requester that did not just finish.
- LOAD:
  - Drive ENB_C=1, MODO_C=11, D_C=captured D, so the counter loads on this edge.
  - Go to RUN with remaining=PASOS if PASOS≠0 and MODO≠11; otherwise go to DONE.
- RUN:
  - Drive ENB_C=1, MODO_C=captured MODO, D_C=captured D.
  - Decrement remaining every cycle; when remaining==1 at this edge, go to DONE.
- DONE:
  - ENB_C=0, MODO_C=00, D_C=0.
  - Register RESULT<=Q_C and RESULT_ID<=captured ID; DONE pulses for this one cycle.
  - Update the pointer and return to IDLE. No new job is accepted in this cycle.
- Arithmetic: RESULT = D + N·step mod 16, where step ∈ {+1, −1, −3} and N=PASOS. MODO 11 or PASOS=0 gives RESULT = D.
- Payload rule: the requester holds VALID and payload stable until READY. Payload is sampled only on the handshake cycle, so later changes are ignored.
- RESET (any state, including mid-RUN):
  - Next state IDLE; pointer 0.
  - ENB_C, MODO_C, D_C, READY0/1, DONE, RESULT, RESULT_ID and BUSY are all 0.
  - The in-flight job is dropped without DONE. The counter keeps its stale Q; the next job always reloads it.

## Timing
- Handshake at edge t: LOAD is cycle t+1, RUN is cycles t+2 … t+1+N, DONE (with valid RESULT) is cycle t+2+N.
- Load-only jobs (MODO 11 or PASOS=0): DONE at t+2.
- Minimum spacing between accepted jobs: N+3 cycles, because IDLE is one cycle after DONE.
- ENB_C, MODO_C and D_C are decoded from the state register and captured job, so they are glitch-free relative to CLK.
- READYn is combinational from state, VALID0/1 and the pointer.

## Structure
- Shared package `contador_pkg`: mode codes MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_DOWN3=2'b10, MODO_LOAD=2'b11; FSM state encoding; counter width (4).
- One sub-module, `arbitro_rr`: 2-way round-robin with a pointer register, update input and one-hot grant.
- The counter itself is external, connected at the next level up on the same CLK.

## Test plan
- Reset, then VALID0 with MODO=00, D=E, PASOS=3 → READY0 at t; counter E→F→0→1; DONE at t+5 with RESULT=1, RESULT_ID=0.
- VALID1 with MODO=10, D=2, PASOS=2 → 2→F→C; DONE at t+4, RESULT=C, RESULT_ID=1.
- After reset, VALID0 and VALID1 held together → req0 served first; req1 accepted in the IDLE cycle after req0's DONE; pointer returns to 0 after req1.
- MODO=11, D=9, PASOS=5 → no RUN cycles; DONE at t+2 with RESULT=9. Separately, MODO=01, D=7, PASOS=0 → DONE at t+2 with RESULT=7.
- RESET asserted during the 3rd RUN cycle of an 8-step job → next cycle IDLE, all outputs 0, no DONE; a new job afterwards completes correctly from its own D.
- PASOS=255 (max) with MODO=01, D=0 → DONE at t+257 with RESULT=1 (0 − 255 mod 16); BUSY high throughout.
